// File: rtl/mlt3_4b5b_pkg.sv
// mlt3_4b5b_pkg
// Shared definitions for the MLT-3 / 4B5B receive path:
//   - ternary line-level encodings and a legality helper
//   - 5-bit control codes (I, J, K, T, R) and the 10-bit J/K delimiter
//   - receiver state enum and decoded symbol-kind enum
`timescale 1ns/1ps
package mlt3_4b5b_pkg;

   localparam logic [1:0] LVL_ZERO    = 2'b00;
   localparam logic [1:0] LVL_PLUS    = 2'b01;
   localparam logic [1:0] LVL_MINUS   = 2'b11;
   localparam logic [1:0] LVL_ILLEGAL = 2'b10;

   localparam logic [4:0] CODE_I = 5'b11111;
   localparam logic [4:0] CODE_J = 5'b11000;
   localparam logic [4:0] CODE_K = 5'b10001;
   localparam logic [4:0] CODE_T = 5'b01101;
   localparam logic [4:0] CODE_R = 5'b00111;

   // Start-of-stream delimiter as it appears in the bit history, J first
   localparam logic [9:0] JK_PATTERN = {CODE_J, CODE_K};

   typedef enum logic [1:0] {
      ST_HUNT,
      ST_DATA,
      ST_WAIT_R
   } rx_state_t;

   typedef enum logic [2:0] {
      SYM_DATA,
      SYM_IDLE,
      SYM_T,
      SYM_R,
      SYM_INVALID
   } sym_kind_t;

   function automatic logic level_is_legal(input logic [1:0] lvl);
      return (lvl == LVL_ZERO) || (lvl == LVL_PLUS) || (lvl == LVL_MINUS);
   endfunction

endpackage

// File: rtl/mlt3_4b5b_receiver_if.sv
// mlt3_4b5b_receiver_if
// Line-side input strobe plus MII-style receive outputs for one pair.
//   LineValid  line strobe, LineLevel carries a new bit
//   LineLevel  00 zero, 01 plus, 11 minus, 10 illegal
//   RxNibble   decoded nibble, meaningful with RxValid
//   RxValid    one-cycle pulse per decoded symbol
//   RxDv       high while a stream is in progress
//   RxEr       one-cycle coding/framing error pulse
//   LinkUp     line activity present
// master: line-side source / consumer of receive outputs; slave: the receiver.
`timescale 1ns/1ps
interface mlt3_4b5b_receiver_if;
   logic       LineValid;
   logic [1:0] LineLevel;
   logic [3:0] RxNibble;
   logic       RxValid;
   logic       RxDv;
   logic       RxEr;
   logic       LinkUp;

   modport master (
      output LineValid, LineLevel,
      input  RxNibble, RxValid, RxDv, RxEr, LinkUp
   );

   modport slave (
      input  LineValid, LineLevel,
      output RxNibble, RxValid, RxDv, RxEr, LinkUp
   );
endinterface

// File: rtl/mlt3_4b5b_receiver_decode_4b5b.sv
// decode_4b5b
// Purely combinational 4B5B symbol classifier.
//   code    in  5-bit code group, first-received bit in the MSB
//   kind    out symbol kind (data, I, T, R, or invalid)
//   nibble  out data nibble, 0 for anything that is not a data code
// J and K are reported as invalid: they only mean something as the
// delimiter pair, which is recognised on the bit history instead.
`timescale 1ns/1ps
module decode_4b5b
   import mlt3_4b5b_pkg::*;
(
   input  logic [4:0] code,
   output sym_kind_t  kind,
   output logic [3:0] nibble
);

   always_comb begin
      kind   = SYM_DATA;
      nibble = 4'h0;
      case (code)
         5'b11110: nibble = 4'h0;
         5'b01001: nibble = 4'h1;
         5'b10100: nibble = 4'h2;
         5'b10101: nibble = 4'h3;
         5'b01010: nibble = 4'h4;
         5'b01011: nibble = 4'h5;
         5'b01110: nibble = 4'h6;
         5'b01111: nibble = 4'h7;
         5'b10010: nibble = 4'h8;
         5'b10011: nibble = 4'h9;
         5'b10110: nibble = 4'hA;
         5'b10111: nibble = 4'hB;
         5'b11010: nibble = 4'hC;
         5'b11011: nibble = 4'hD;
         5'b11100: nibble = 4'hE;
         5'b11101: nibble = 4'hF;
         CODE_I:   kind   = SYM_IDLE;
         CODE_T:   kind   = SYM_T;
         CODE_R:   kind   = SYM_R;
         default:  kind   = SYM_INVALID;
      endcase
   end

endmodule

// File: rtl/mlt3_4b5b_receiver.sv
// mlt3_4b5b_receiver
// Receive decoder for one pair: MLT-3 to bits, J/K alignment, 4B5B decode
// to nibbles with data-valid / error flags, and link-loss detection.
//   Clock100MhzP  system clock, rising edge
//   ResetN        asynchronous active-low reset
//   rx            slave side of mlt3_4b5b_receiver_if (line in, MII-style out)
// Parameters: LOSS_LIMIT strobes without a transition drop LinkUp;
//             LOSS_W is the loss counter width and must hold LOSS_LIMIT.
`timescale 1ns/1ps
module mlt3_4b5b_receiver
   import mlt3_4b5b_pkg::*;
#(
   parameter int LOSS_LIMIT = 64,
   parameter int LOSS_W     = 7
) (
   input logic                  Clock100MhzP,
   input logic                  ResetN,
   mlt3_4b5b_receiver_if.slave  rx
);

   rx_state_t          state, next_state;
   logic [1:0]         prev_level;
   // Nine stored bits; the bit arriving this strobe completes the 10-bit window
   logic [8:0]         history;
   logic [2:0]         bit_cnt;
   logic               bad_flag;
   logic [LOSS_W-1:0]  loss_cnt;

   logic               level_ok, line_bit, bad_now;
   logic [9:0]         hist_next;
   logic [LOSS_W-1:0]  loss_next;
   logic               loss_hit, sym_done, jk_hit;
   sym_kind_t          dec_kind, kind_eff;
   logic [3:0]         dec_nibble;

   logic [3:0]         nibble_d;
   logic               valid_d, er_d, dv_d, link_d;

   // Per-strobe bit recovery and event detection; illegal levels read as 0
   always_comb begin
      level_ok  = level_is_legal(rx.LineLevel);
      line_bit  = level_ok && (rx.LineLevel != prev_level);
      hist_next = {history, line_bit};
      bad_now   = bad_flag | ~level_ok;
      if (line_bit)
         loss_next = '0;
      else if (loss_cnt == LOSS_W'(LOSS_LIMIT))
         loss_next = loss_cnt;
      else
         loss_next = loss_cnt + LOSS_W'(1);
      loss_hit  = rx.LineValid && (loss_next == LOSS_W'(LOSS_LIMIT));
      sym_done  = rx.LineValid && (state != ST_HUNT) && (bit_cnt == 3'd4);
      jk_hit    = rx.LineValid && (state == ST_HUNT) && (hist_next == JK_PATTERN);
   end

   decode_4b5b u_decode (
      .code   (hist_next[4:0]),
      .kind   (dec_kind),
      .nibble (dec_nibble)
   );

   // A symbol that saw an illegal level is untrustworthy whatever its code
   assign kind_eff = bad_now ? SYM_INVALID : dec_kind;

   // Bit-level datapath: previous level, history, symbol position, bad flag, loss counter
   always_ff @(posedge Clock100MhzP or negedge ResetN) begin
      if (!ResetN) begin
         prev_level <= LVL_ZERO;
         history    <= '0;
         bit_cnt    <= '0;
         bad_flag   <= 1'b0;
         loss_cnt   <= '0;
      end else if (rx.LineValid) begin
         if (level_ok)
            prev_level <= rx.LineLevel;
         history  <= hist_next[8:0];
         loss_cnt <= loss_next;
         if (jk_hit)
            bit_cnt <= '0;
         else if (state != ST_HUNT)
            bit_cnt <= (bit_cnt == 3'd4) ? 3'd0 : bit_cnt + 3'd1;
         bad_flag <= (jk_hit || sym_done) ? 1'b0 : bad_now;
      end
   end

   // State register
   always_ff @(posedge Clock100MhzP or negedge ResetN) begin
      if (!ResetN)
         state <= ST_HUNT;
      else
         state <= next_state;
   end

   // Next-state logic; loss of link outranks a symbol completing on the same strobe
   always_comb begin
      next_state = state;
      case (state)
         ST_HUNT: begin
            if (jk_hit)
               next_state = ST_DATA;
         end
         ST_DATA: begin
            if (loss_hit)
               next_state = ST_HUNT;
            else if (sym_done && kind_eff == SYM_T)
               next_state = ST_WAIT_R;
            else if (sym_done && kind_eff == SYM_IDLE)
               next_state = ST_HUNT;
         end
         ST_WAIT_R: begin
            if (loss_hit || sym_done)
               next_state = ST_HUNT;
         end
         default: next_state = ST_HUNT;
      endcase
   end

   // Output logic: next values of the registered outputs
   always_comb begin
      nibble_d = rx.RxNibble;
      valid_d  = 1'b0;
      er_d     = 1'b0;
      dv_d     = rx.RxDv;
      link_d   = rx.LinkUp;
      if (rx.LineValid && line_bit)
         link_d = 1'b1;
      else if (loss_hit)
         link_d = 1'b0;
      case (state)
         ST_HUNT: begin
            if (jk_hit)
               dv_d = 1'b1;
         end
         ST_DATA: begin
            if (loss_hit) begin
               er_d = 1'b1;
               dv_d = 1'b0;
            end else if (sym_done) begin
               case (kind_eff)
                  SYM_DATA: begin
                     valid_d  = 1'b1;
                     nibble_d = dec_nibble;
                  end
                  SYM_T: ;
                  SYM_IDLE: begin
                     er_d = 1'b1;
                     dv_d = 1'b0;
                  end
                  default: begin
                     valid_d  = 1'b1;
                     er_d     = 1'b1;
                     nibble_d = 4'h0;
                  end
               endcase
            end
         end
         ST_WAIT_R: begin
            if (loss_hit || sym_done) begin
               dv_d = 1'b0;
               er_d = loss_hit || (kind_eff != SYM_R);
            end
         end
         default: ;
      endcase
   end

   // Output registers
   always_ff @(posedge Clock100MhzP or negedge ResetN) begin
      if (!ResetN) begin
         rx.RxNibble <= 4'h0;
         rx.RxValid  <= 1'b0;
         rx.RxDv     <= 1'b0;
         rx.RxEr     <= 1'b0;
         rx.LinkUp   <= 1'b0;
      end else begin
         rx.RxNibble <= nibble_d;
         rx.RxValid  <= valid_d;
         rx.RxDv     <= dv_d;
         rx.RxEr     <= er_d;
         rx.LinkUp   <= link_d;
      end
   end

endmodule

// File: tb/tb_mlt3_4b5b_receiver.sv
// tb_mlt3_4b5b_receiver
// Directed bench for mlt3_4b5b_receiver (LOSS_LIMIT = 8). A local MLT-3
// encoder turns hand-written bit/code sequences into line levels; a
// negedge monitor records every RxValid nibble and RxEr pulse.
`timescale 1ns/1ps
module tb_mlt3_4b5b_receiver;

   logic clk;
   logic rst_n;
   mlt3_4b5b_receiver_if bif ();

   mlt3_4b5b_receiver #(.LOSS_LIMIT(8), .LOSS_W(4)) dut (
      .Clock100MhzP (clk),
      .ResetN       (rst_n),
      .rx           (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int assert_count = 0;
   int fail_count   = 0;

   // MLT-3 encoder phase: 0 -> zero, 1 -> plus, 2 -> zero, 3 -> minus
   logic [1:0] phase;

   logic [3:0] nib_q[$];
   logic       erv_q[$];
   int         er_count = 0;
   int         er_base;

   // Record every decoded symbol and every error pulse
   always @(negedge clk) begin
      if (rst_n) begin
         if (bif.RxValid) begin
            nib_q.push_back(bif.RxNibble);
            erv_q.push_back(bif.RxEr);
         end
         if (bif.RxEr)
            er_count++;
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [1:0] level_of(input logic [1:0] ph);
      case (ph)
         2'd1:    return 2'b01;
         2'd3:    return 2'b11;
         default: return 2'b00;
      endcase
   endfunction

   task automatic send_bit(input logic b);
      if (b) phase = phase + 2'd1;
      bif.LineValid = 1'b1;
      bif.LineLevel = level_of(phase);
      @(posedge clk); #1;
      bif.LineValid = 1'b0;
   endtask

   task automatic send_illegal();
      bif.LineValid = 1'b1;
      bif.LineLevel = 2'b10;
      @(posedge clk); #1;
      bif.LineValid = 1'b0;
   endtask

   task automatic send_sym(input logic [4:0] c);
      for (int i = 4; i >= 0; i--) send_bit(c[i]);
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic start_scenario();
      nib_q.delete();
      erv_q.delete();
      er_base = er_count;
   endtask

   task automatic test_reset();
      bif.LineValid = 1'b0;
      bif.LineLevel = 2'b00;
      phase = 2'd0;
      rst_n = 1'b0;
      idle_cycles(3);
      assert_count++; if (bif.RxNibble !== 4'h0) begin fail_count++; $display("[TB] FAIL reset_nibble: got %h want 0", bif.RxNibble); end
      assert_count++; if (bif.RxValid !== 1'b0) begin fail_count++; $display("[TB] FAIL reset_valid: got %b want 0", bif.RxValid); end
      assert_count++; if (bif.RxDv !== 1'b0) begin fail_count++; $display("[TB] FAIL reset_dv: got %b want 0", bif.RxDv); end
      assert_count++; if (bif.RxEr !== 1'b0) begin fail_count++; $display("[TB] FAIL reset_er: got %b want 0", bif.RxEr); end
      assert_count++; if (bif.LinkUp !== 1'b0) begin fail_count++; $display("[TB] FAIL reset_link: got %b want 0", bif.LinkUp); end
      rst_n = 1'b1;
      idle_cycles(2);
   endtask

   task automatic test_idle_packet();
      logic [3:0] exp_nib [3] = '{4'h5, 4'hD, 4'hA};
      start_scenario();
      send_sym(5'b11111);
      send_sym(5'b11111);
      send_sym(5'b11000);
      send_bit(1); send_bit(0); send_bit(0); send_bit(0);
      assert_count++; if (bif.RxDv !== 1'b0) begin fail_count++; $display("[TB] FAIL pkt_dv_before_k: got %b want 0", bif.RxDv); end
      send_bit(1);
      assert_count++; if (bif.RxDv !== 1'b1) begin fail_count++; $display("[TB] FAIL pkt_dv_rise: got %b want 1", bif.RxDv); end
      assert_count++; if (bif.RxValid !== 1'b0) begin fail_count++; $display("[TB] FAIL pkt_jk_no_valid: got %b want 0", bif.RxValid); end
      send_sym(5'b01011);
      assert_count++; if (bif.RxValid !== 1'b1 || bif.RxNibble !== 4'h5) begin fail_count++; $display("[TB] FAIL pkt_first_valid: valid=%b nibble=%h want 1/5", bif.RxValid, bif.RxNibble); end
      send_bit(1);
      assert_count++; if (bif.RxValid !== 1'b0) begin fail_count++; $display("[TB] FAIL pkt_valid_width: got %b want 0", bif.RxValid); end
      send_bit(1); send_bit(0); send_bit(1); send_bit(1);
      send_sym(5'b10110);
      send_sym(5'b01101);
      assert_count++; if (bif.RxDv !== 1'b1 || bif.RxValid !== 1'b0) begin fail_count++; $display("[TB] FAIL pkt_after_t: dv=%b valid=%b want 1/0", bif.RxDv, bif.RxValid); end
      send_bit(0); send_bit(0); send_bit(1); send_bit(1);
      assert_count++; if (bif.RxDv !== 1'b1) begin fail_count++; $display("[TB] FAIL pkt_dv_during_r: got %b want 1", bif.RxDv); end
      send_bit(1);
      assert_count++; if (bif.RxDv !== 1'b0) begin fail_count++; $display("[TB] FAIL pkt_dv_fall: got %b want 0", bif.RxDv); end
      idle_cycles(3);
      assert_count++; if (nib_q.size() != 3) begin fail_count++; $display("[TB] FAIL pkt_count: got %0d want 3", nib_q.size()); end
      for (int i = 0; i < 3 && i < nib_q.size(); i++) begin
         assert_count++; if (nib_q[i] !== exp_nib[i]) begin fail_count++; $display("[TB] FAIL pkt_nibble[%0d]: got %h want %h", i, nib_q[i], exp_nib[i]); end
      end
      assert_count++; if (er_count - er_base != 0) begin fail_count++; $display("[TB] FAIL pkt_er: got %0d pulses want 0", er_count - er_base); end
      assert_count++; if (bif.LinkUp !== 1'b1) begin fail_count++; $display("[TB] FAIL pkt_link: got %b want 1", bif.LinkUp); end
   endtask

   task automatic test_misaligned();
      start_scenario();
      send_bit(1); send_bit(0); send_bit(1);
      send_sym(5'b11000);
      send_sym(5'b10001);
      assert_count++; if (bif.RxDv !== 1'b1) begin fail_count++; $display("[TB] FAIL mis_dv: got %b want 1", bif.RxDv); end
      send_sym(5'b10101);
      send_sym(5'b01101);
      send_sym(5'b00111);
      idle_cycles(3);
      assert_count++; if (nib_q.size() != 1) begin fail_count++; $display("[TB] FAIL mis_count: got %0d want 1", nib_q.size()); end
      if (nib_q.size() > 0) begin
         assert_count++; if (nib_q[0] !== 4'h3) begin fail_count++; $display("[TB] FAIL mis_nibble: got %h want 3", nib_q[0]); end
      end
      assert_count++; if (er_count - er_base != 0) begin fail_count++; $display("[TB] FAIL mis_er: got %0d pulses want 0", er_count - er_base); end
      assert_count++; if (bif.RxDv !== 1'b0) begin fail_count++; $display("[TB] FAIL mis_dv_end: got %b want 0", bif.RxDv); end
   endtask

   task automatic test_invalid_symbol();
      start_scenario();
      send_sym(5'b11000);
      send_sym(5'b10001);
      send_sym(5'b00000);
      assert_count++; if (bif.RxValid !== 1'b1 || bif.RxEr !== 1'b1 || bif.RxNibble !== 4'h0) begin fail_count++; $display("[TB] FAIL inv_flags: valid=%b er=%b nibble=%h want 1/1/0", bif.RxValid, bif.RxEr, bif.RxNibble); end
      assert_count++; if (bif.RxDv !== 1'b1) begin fail_count++; $display("[TB] FAIL inv_dv: got %b want 1", bif.RxDv); end
      send_sym(5'b01111);
      assert_count++; if (bif.RxValid !== 1'b1 || bif.RxEr !== 1'b0 || bif.RxNibble !== 4'h7) begin fail_count++; $display("[TB] FAIL inv_next: valid=%b er=%b nibble=%h want 1/0/7", bif.RxValid, bif.RxEr, bif.RxNibble); end
      assert_count++; if (bif.RxDv !== 1'b1) begin fail_count++; $display("[TB] FAIL inv_dv2: got %b want 1", bif.RxDv); end
      send_sym(5'b01101);
      send_sym(5'b00111);
      idle_cycles(3);
      assert_count++; if (nib_q.size() != 2) begin fail_count++; $display("[TB] FAIL inv_count: got %0d want 2", nib_q.size()); end
      assert_count++; if (er_count - er_base != 1) begin fail_count++; $display("[TB] FAIL inv_er: got %0d pulses want 1", er_count - er_base); end
   endtask

   task automatic test_illegal_level();
      logic [3:0] exp_nib [3] = '{4'h2, 4'h0, 4'h4};
      logic       exp_er  [3] = '{1'b0, 1'b1, 1'b0};
      start_scenario();
      send_sym(5'b11000);
      send_sym(5'b10001);
      send_sym(5'b10100);
      send_bit(1); send_bit(0); send_illegal(); send_bit(1); send_bit(1);
      assert_count++; if (bif.RxValid !== 1'b1 || bif.RxEr !== 1'b1 || bif.RxNibble !== 4'h0) begin fail_count++; $display("[TB] FAIL ill_flags: valid=%b er=%b nibble=%h want 1/1/0", bif.RxValid, bif.RxEr, bif.RxNibble); end
      send_sym(5'b01010);
      send_sym(5'b01101);
      send_sym(5'b00111);
      idle_cycles(3);
      assert_count++; if (nib_q.size() != 3) begin fail_count++; $display("[TB] FAIL ill_count: got %0d want 3", nib_q.size()); end
      for (int i = 0; i < 3 && i < nib_q.size(); i++) begin
         assert_count++; if (nib_q[i] !== exp_nib[i] || erv_q[i] !== exp_er[i]) begin fail_count++; $display("[TB] FAIL ill_sym[%0d]: nibble=%h er=%b want %h/%b", i, nib_q[i], erv_q[i], exp_nib[i], exp_er[i]); end
      end
      assert_count++; if (er_count - er_base != 1) begin fail_count++; $display("[TB] FAIL ill_er: got %0d pulses want 1", er_count - er_base); end
   endtask

   // J inside DATA is an invalid symbol whose last three bits start the idle
   // run; five more zeros make the eighth constant strobe a symbol boundary
   task automatic test_link_loss();
      start_scenario();
      send_sym(5'b11000);
      send_sym(5'b10001);
      send_sym(5'b10101);
      send_sym(5'b11000);
      assert_count++; if (bif.RxValid !== 1'b1 || bif.RxEr !== 1'b1 || bif.RxNibble !== 4'h0) begin fail_count++; $display("[TB] FAIL loss_midj: valid=%b er=%b nibble=%h want 1/1/0", bif.RxValid, bif.RxEr, bif.RxNibble); end
      repeat (4) send_bit(0);
      assert_count++; if (bif.LinkUp !== 1'b1 || bif.RxDv !== 1'b1) begin fail_count++; $display("[TB] FAIL loss_early: link=%b dv=%b want 1/1", bif.LinkUp, bif.RxDv); end
      send_bit(0);
      assert_count++; if (bif.LinkUp !== 1'b0) begin fail_count++; $display("[TB] FAIL loss_link: got %b want 0", bif.LinkUp); end
      assert_count++; if (bif.RxEr !== 1'b1) begin fail_count++; $display("[TB] FAIL loss_er: got %b want 1", bif.RxEr); end
      assert_count++; if (bif.RxValid !== 1'b0) begin fail_count++; $display("[TB] FAIL loss_no_valid: got %b want 0", bif.RxValid); end
      assert_count++; if (bif.RxDv !== 1'b0) begin fail_count++; $display("[TB] FAIL loss_dv: got %b want 0", bif.RxDv); end
      idle_cycles(3);
      assert_count++; if (nib_q.size() != 2) begin fail_count++; $display("[TB] FAIL loss_count: got %0d want 2", nib_q.size()); end
      assert_count++; if (er_count - er_base != 2) begin fail_count++; $display("[TB] FAIL loss_er_total: got %0d pulses want 2", er_count - er_base); end
   endtask

   task automatic test_t_without_r();
      start_scenario();
      send_sym(5'b11000);
      send_sym(5'b10001);
      send_sym(5'b01001);
      assert_count++; if (bif.RxValid !== 1'b1 || bif.RxNibble !== 4'h1) begin fail_count++; $display("[TB] FAIL tnr_valid: valid=%b nibble=%h want 1/1", bif.RxValid, bif.RxNibble); end
      send_sym(5'b01101);
      send_sym(5'b11111);
      assert_count++; if (bif.RxEr !== 1'b1 || bif.RxDv !== 1'b0 || bif.RxValid !== 1'b0) begin fail_count++; $display("[TB] FAIL tnr_end: er=%b dv=%b valid=%b want 1/0/0", bif.RxEr, bif.RxDv, bif.RxValid); end
      send_sym(5'b01011);
      idle_cycles(3);
      assert_count++; if (nib_q.size() != 1) begin fail_count++; $display("[TB] FAIL tnr_hunt: got %0d symbols want 1", nib_q.size()); end
      assert_count++; if (er_count - er_base != 1) begin fail_count++; $display("[TB] FAIL tnr_er: got %0d pulses want 1", er_count - er_base); end
   endtask

   task automatic test_async_reset();
      start_scenario();
      send_sym(5'b11000);
      send_sym(5'b10001);
      send_bit(0); send_bit(1);
      #2 rst_n = 1'b0;
      #1;
      assert_count++; if (bif.RxDv !== 1'b0 || bif.LinkUp !== 1'b0) begin fail_count++; $display("[TB] FAIL arst_clear: dv=%b link=%b want 0/0", bif.RxDv, bif.LinkUp); end
      idle_cycles(2);
      rst_n = 1'b1;
      phase = 2'd0;
      idle_cycles(1);
      start_scenario();
      send_sym(5'b01011);
      idle_cycles(2);
      assert_count++; if (nib_q.size() != 0) begin fail_count++; $display("[TB] FAIL arst_need_jk: got %0d symbols want 0", nib_q.size()); end
      send_sym(5'b11000);
      send_sym(5'b10001);
      send_sym(5'b10011);
      send_sym(5'b01101);
      send_sym(5'b00111);
      idle_cycles(3);
      assert_count++; if (nib_q.size() != 1 || (nib_q.size() > 0 && nib_q[0] !== 4'h9)) begin fail_count++; $display("[TB] FAIL arst_stream: count=%0d want 1 with nibble 9", nib_q.size()); end
   endtask

   initial begin
      test_reset();
      test_idle_packet();
      idle_cycles(2);
      test_misaligned();
      idle_cycles(2);
      test_invalid_symbol();
      idle_cycles(2);
      test_illegal_level();
      idle_cycles(2);
      test_link_loss();
      idle_cycles(2);
      test_t_without_r();
      idle_cycles(2);
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule

// File: doc/mlt3_4b5b_receiver.md
# mlt3_4b5b_receiver

Line-side receive decoder for one TIA-568B pair, directly downstream of the per-pair differential decode stage. It consumes one ternary MLT-3 line level per bit strobe and recovers the bit stream. It aligns on the J/K start-of-stream delimiter and decodes 4B5B symbols into MII-style nibbles with data-valid and error flags. Link-loss detection is included; one instance per pair.

## Interface
- LOSS_LIMIT, 64: consecutive LineValid strobes without a level transition before LinkUp drops (≥2).
- LOSS_W, 7: width of the loss counter; must hold LOSS_LIMIT.
- Clock100MhzP  in  1  single system clock, rising edge.
- ResetN  in  1  reset, asynchronous assert, active-low.
- LineValid  in  1  strobe: LineLevel carries one new line bit this cycle.
- LineLevel  in  2  00 zero, 01 plus, 11 minus, 10 illegal.
- RxNibble  out  4  decoded data nibble; meaningful only with RxValid.
- RxValid  out  1  one-cycle pulse per decoded symbol in a stream.
- RxDv  out  1  high from delimiter acceptance to end of stream.
- RxEr  out  1  one-cycle pulse flagging a coding or framing error.
- LinkUp  out  1  line activity present.

## Operation
- MLT-3 decode on each LineValid: bit = 1 if LineLevel ≠ previous level, else 0; previous level then updates.
- Illegal level 10: bit = 0, previous level unchanged, sticky "bad" flag set for the current symbol.
- LineValid low: all state holds.
- Bits shift into a 10-bit history register; first-received bit is the code MSB.
- 4B5B data codes:
  - 0–3: 11110, 01001, 10100, 10101
  - 4–7: 01010, 01011, 01110, 01111
  - 8–B: 10010, 10011, 10110, 10111
  - C–F: 11010, 11011, 11100, 11101
- Control codes: I 11111, J 11000, K 10001, T 01101, R 00111.
- States:
  - HUNT (reset): on each bit, compare history with 1100010001 (J then K). On match: → DATA, symbol bit counter = 0, RxDv set. J/K themselves emit no nibble.
  - DATA, every 5th bit:
    - Data code, bad flag clear: RxValid pulse with the nibble.
    - T: → WAIT_R, no pulse.
    - I: premature end. RxEr pulse, RxDv clear, → HUNT.
    - Any other code, or bad flag set: RxValid and RxEr pulse together, RxNibble = 0, stay in DATA.
  - WAIT_R, 5th bit:
    - R: RxDv clear, → HUNT.
    - Otherwise: RxEr pulse, RxDv clear, → HUNT.
- Bad flag clears at every symbol boundary and on entry to DATA.
- Loss counter:
  - Cleared on each transition-bit (bit = 1); counts up on each bit = 0 and each illegal level; saturates at LOSS_LIMIT.
  - LinkUp = 1 on any transition-bit; LinkUp = 0 when the counter reaches LOSS_LIMIT.
  - Loss while in DATA or WAIT_R: RxEr pulse, RxDv clear, → HUNT.
- Loss on the same strobe as a symbol completion: loss wins, and no RxValid is emitted.

## Timing
- All outputs are registered.
- Reset values: RxNibble 0, RxValid 0, RxDv 0, RxEr 0, LinkUp 0. Also: state HUNT, previous level 00, history 0, counters 0.
- RxValid/RxEr: asserted the cycle after the LineValid carrying a symbol's 5th bit; high exactly one cycle.
- RxDv: rises the cycle after K's last bit; falls the cycle after R's last bit (or after the error event).
- Async reset mid-stream: outputs clear immediately; the next stream needs a fresh J/K.
- Back-to-back strobes (LineValid every cycle) are sustained with no dropped bits.

## Structure
- Package mlt3_4b5b_pkg holds:
  - line-level encodings;
  - 5-bit control codes (I, J, K, T, R) and the JK 10-bit pattern;
  - state enum (HUNT, DATA, WAIT_R);
  - symbol-kind enum (DATA, IDLE, T, R, INVALID).
- Sub-module decode_4b5b: purely combinational, 5-bit code → {kind, nibble}. Separately unit-testable.

## Test plan
- Idle then packet: I, I, J, K, symbols for 0x5, 0xD, 0xA, then T, R. Required: RxValid ×3 with nibbles 5, D, A. RxDv high from the cycle after K until the cycle after R. RxEr never.
- Misaligned J/K: 3 stray bits (1,0,1) before J, K, 0x3, T, R. Required: alignment still found; one RxValid with nibble 3.
- Invalid symbol mid-stream: J, K, 00000, 0x7, T, R. Required:
  - 00000 → RxValid and RxEr with RxNibble 0;
  - 0x7 → RxValid, no RxEr;
  - RxDv stays high throughout.
- Illegal level: LineLevel 10 inside the second data symbol. Required: that symbol flagged RxEr with RxNibble 0; the next symbol decodes cleanly.
- Link loss: with LOSS_LIMIT=8, mid-DATA hold LineLevel constant for 8 strobes. Required: LinkUp → 0, RxEr pulse, RxDv → 0. Also verify a symbol completing on the 8th strobe emits no RxValid.
- T not followed by R: J, K, 0x1, T, I. Required: RxValid for nibble 1; RxEr on the I; RxDv drops; state back in HUNT.
